fpu_norm_round: RTL and testbench
=================================

# fpu_norm_round

Post-addition normalize-and-round stage of the single-precision FPU. Accepts the raw fraction, carry, larger exponent and result sign from the fraction-adder stage, then runs a multi-cycle sequence. The sequence aligns on carry, shifts left one bit per cycle until the hidden bit is set, and rounds to nearest-even using guard/round/sticky bits. It packs a 32-bit IEEE-754 word with a start/done handshake.

## Interface
Parameters: none.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- sign_in  in  1  result sign from sign logic
- exp_in  in  8  biased exponent of the larger operand
- carry_in  in  1  adder carry-out (weight 2.0)
- mant_in  in  27  {hidden, frac[22:0], G, R, S}
- R  out  32  packed result {sign, exp[7:0], frac[22:0]}; held until next start
- done  out  1  one-cycle pulse, R valid in same cycle
- busy  out  1  high from the cycle after start is accepted until done

## Operation
- States: IDLE, ALIGN, NORM, ROUND, DONE.
- IDLE: on start, register sign_in, exp_in, carry_in and mant_in; go to ALIGN. busy is set.
- ALIGN, case exp_in == 255: result is {sign, 8'hFF, mant[25:3]}; go to DONE.
- ALIGN, case carry = 1: mant = {1, mant[26:1]} with new S = old S | old R; exp += 1.
- ALIGN, case carry = 1 and new exp = 255: result is ±inf {sign, 8'hFF, 0}; go to DONE.
- ALIGN, otherwise: go to NORM.
- NORM, each cycle: if mant[26] = 0, mant ≠ 0 and exp > 1, shift mant left by 1 (S shifts in 0) and decrement exp; stay in NORM. Otherwise go to ROUND.
- NORM, zero mantissa (mant = 0): result is {sign, 31'b0}, i.e. signed zero.
- NORM, exit with mant[26] = 0: the result is denormal and packs exp field 0.
- ROUND: round up when G & (R | S | frac[0]). Add 1 to the 24-bit {hidden, frac}.
- ROUND, add overflows 24 bits: mantissa becomes 1.0 and exp += 1.
- ROUND, exp reaches 255 after rounding: result is ±inf.
- ROUND, denormal whose rounding sets hidden: packs exp 1.
- DONE: R is registered and done = 1 for one cycle; return to IDLE.
- Any start asserted outside IDLE is ignored; there is no queuing.
- Width rules: exp is handled internally as 9 bits to detect 255 without wrap. The guard, round and sticky bits are never packed.

## Timing
- Reset values: R = 32'h0, done = 0, busy = 0, state = IDLE.
- k = number of NORM shifts, 0 ≤ k ≤ 26.
- done is high in the cycle following the (k+3)th rising edge after the start-sampling edge.
- The ALIGN exception paths skip NORM and ROUND; done is high after 2 edges.
- Back-to-back: start can be accepted in the cycle done is high, because the state returns to IDLE on that edge.
- Reset mid-operation: rst has priority over all transitions. On the next edge the state is IDLE, done = 0, busy = 0, R = 0, and any in-flight result is discarded.
- start and rst asserted together: rst wins and start is dropped.

## Configuration
- FPU_ROUND_EN defined: the ROUND state is present and rounding is round-to-nearest-even as described.
- FPU_ROUND_EN undefined: truncation. NORM goes directly to DONE, G/R/S are discarded, and the normal-path latency is k+2 edges.

## Test plan
- Simple 1.0: sign 0, exp 127, carry 0, mant 27'h4000000 -> R = 32'h3F800000. done 3 edges after start. busy is high exactly in between.
- Carry align: exp 127, carry 1, mant 27'h4000000 -> R = 32'h40400000 (3.0).
- Left normalize: exp 127, carry 0, mant 27'h0800000 -> R = 32'h3E000000 with k = 3, so done 6 edges after start.
- Rounding, three cases (exp 127):
  - mant 27'h4000014 (frac 1, G = 1) -> R = 32'h3F800002.
  - mant 27'h4000004 (tie, even) -> R = 32'h3F800000.
  - mant 27'h7FFFFFE -> R = 32'h40000000.
  - With FPU_ROUND_EN off, all three truncate.
- Specials:
  - exp 254, carry 1 -> R = 32'h7F800000.
  - sign 1, mant 0 -> R = 32'h80000000.
  - exp 1, mant 27'h2000000 -> R = 32'h00400000 (denormal).
- Control: pulse start during NORM -> ignored. Assert rst during NORM -> next edge done = 0, busy = 0, R = 0. A subsequent start then completes normally.

Source files
------------

// File: rtl/fpu_norm_round.sv
// rtl/fpu_norm_round.sv - FPU post-add normalize, round-to-nearest-even and pack stage
//
// Purpose: takes the fraction-adder result and runs one multi-cycle pass.
// The pass aligns on carry, shifts left one bit per cycle until the hidden
// bit is set, optionally rounds, and then packs an IEEE-754 single.
//
// Build option: FPU_ROUND_EN
//   defined   - ROUND state present, round-to-nearest-even on G/R/S
//   undefined - truncation, NORM packs directly
//
// Ports:
//   clk       in   1   clock, all state on rising edge
//   rst       in   1   synchronous active-high reset
//   start     in   1   request, sampled only in IDLE
//   sign_in   in   1   result sign
//   exp_in    in   8   biased exponent of the larger operand
//   carry_in  in   1   adder carry-out (weight 2.0)
//   mant_in   in  27   {hidden, frac[22:0], G, R, S}
//   R         out 32   packed result, held until the next result
//   done      out  1   one-cycle pulse, R valid in the same cycle
//   busy      out  1   high while an operation is in flight
`timescale 1ns/1ps

module fpu_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic        carry_in,
  input  logic [26:0] mant_in,
  output logic [31:0] R,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ALIGN, NORM, ROUND, DONE} stateT;

  stateT       state, stateNext;
  logic        signReg, signNext;
  logic [8:0]  expReg, expNext;      // 9 bits so 255 is seen without wrap
  logic        carryReg, carryNext;
  logic [26:0] mantReg, mantNext;
  logic [31:0] staged, stagedNext;   // result of the ALIGN special cases
  logic [31:0] rNext;
  logic        doneNext;

`ifdef FPU_ROUND_EN
  logic        roundUp;
  logic [24:0] sum25;
`endif

  // Pack sign/exponent/24-bit significand. A clear hidden bit means a
  // denormal (exp field 0); a set hidden bit never packs exp 0.
  function automatic logic [31:0] pack(input logic s, input logic [8:0] e,
                                       input logic [23:0] sig);
    if (e >= 9'd255)
      return {s, 8'hFF, 23'd0};
    else if (sig[23])
      return {s, (e == 9'd0) ? 8'd1 : e[7:0], sig[22:0]};
    else
      return {s, 8'd0, sig[22:0]};
  endfunction

  always_comb begin
    stateNext  = state;
    signNext   = signReg;
    expNext    = expReg;
    carryNext  = carryReg;
    mantNext   = mantReg;
    stagedNext = staged;
    rNext      = R;
    doneNext   = 1'b0;
`ifdef FPU_ROUND_EN
    roundUp    = 1'b0;
    sum25      = 25'd0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          signNext  = sign_in;
          expNext   = {1'b0, exp_in};
          carryNext = carry_in;
          mantNext  = mant_in;
          stateNext = ALIGN;
        end
      end
      ALIGN: begin
        if (expReg == 9'd255) begin
          stagedNext = {signReg, 8'hFF, mantReg[25:3]};
          stateNext  = DONE;
        end else if (carryReg) begin
          // Shift right one; the bit falling off folds into sticky.
          mantNext = {1'b1, mantReg[26:2], mantReg[1] | mantReg[0]};
          expNext  = expReg + 9'd1;
          if (expReg == 9'd254) begin
            stagedNext = {signReg, 8'hFF, 23'd0};
            stateNext  = DONE;
          end else begin
            stateNext = NORM;
          end
        end else begin
          stateNext = NORM;
        end
      end
      NORM: begin
        if (!mantReg[26] && (mantReg != 27'd0) && (expReg > 9'd1)) begin
          mantNext = {mantReg[25:0], 1'b0};
          expNext  = expReg - 9'd1;
        end else begin
`ifdef FPU_ROUND_EN
          stateNext = ROUND;
`else
          rNext     = pack(signReg, expReg, mantReg[26:3]);
          doneNext  = 1'b1;
          stateNext = IDLE;
`endif
        end
      end
`ifdef FPU_ROUND_EN
      ROUND: begin
        roundUp = mantReg[2] & (mantReg[1] | mantReg[0] | mantReg[3]);
        sum25   = {1'b0, mantReg[26:3]} + {24'd0, roundUp};
        if (sum25[24])
          rNext = pack(signReg, expReg + 9'd1, 24'h800000);
        else
          rNext = pack(signReg, expReg, sum25[23:0]);
        doneNext  = 1'b1;
        stateNext = IDLE;
      end
`endif
      // Only the ALIGN special cases pass through here, which gives them
      // their two-edge latency; the normal path completes straight to IDLE.
      DONE: begin
        rNext     = staged;
        doneNext  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      signReg  <= 1'b0;
      expReg   <= 9'd0;
      carryReg <= 1'b0;
      mantReg  <= 27'd0;
      staged   <= 32'd0;
      R        <= 32'd0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      signReg  <= signNext;
      expReg   <= expNext;
      carryReg <= carryNext;
      mantReg  <= mantNext;
      staged   <= stagedNext;
      R        <= rNext;
      done     <= doneNext;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb/tb_fpu_norm_round.sv - self-checking bench for fpu_norm_round
`timescale 1ns/1ps

module tb_fpu_norm_round;

`ifdef FPU_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic        carry_in;
  logic [26:0] mant_in;
  logic [31:0] R;
  logic        done;
  logic        busy;

  fpu_norm_round dut (
    .clk(clk), .rst(rst), .start(start), .sign_in(sign_in), .exp_in(exp_in),
    .carry_in(carry_in), .mant_in(mant_in), .R(R), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nPass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    bit        s;
    bit [7:0]  e;
    bit        c;
    bit [26:0] m;
    bit [31:0] rRound;
    int        latRound;
    bit [31:0] rTrunc;
    int        latTrunc;
    int        glitch;
  } vecT;

  vecT vecs[$];

  // Value model: F is the significand with 1.0 at bit 26; normalization is a
  // leading-one count clamped by the exponent floor, rounding compares the
  // three dropped bits against one half.
  task automatic model(input bit s, input bit [7:0] e, input bit c, input bit [26:0] m,
                       output bit [31:0] r, output int lat);
    longint f, keep, rem;
    int ex, k, msb, limit;
    if (e == 8'hFF) begin
      r = {s, 8'hFF, m[25:3]};
      lat = 2;
      return;
    end
    f  = longint'(m);
    ex = int'(e);
    if (c) begin
      f  = (64'd1 << 26) | (f >> 1) | (f & 64'd1);
      ex = ex + 1;
      if (ex == 255) begin
        r = {s, 8'hFF, 23'd0};
        lat = 2;
        return;
      end
    end
    msb = 26;
    for (int b = 0; b <= 26; b++) if (f[b]) msb = b;
    limit = (ex > 1) ? ex - 1 : 0;
    k = (f == 0) ? 0 : (((26 - msb) < limit) ? (26 - msb) : limit);
    f  = f << k;
    ex = ex - k;
    keep = f >> 3;
    rem  = f & 64'd7;
    if (ROUND_EN) begin
      if (rem > 4 || (rem == 4 && keep[0])) keep = keep + 1;
      lat = k + 3;
    end else begin
      lat = k + 2;
    end
    if (keep == (64'd1 << 24)) begin
      keep = 64'd1 << 23;
      ex = ex + 1;
    end
    if (ex >= 255) r = {s, 8'hFF, 23'd0};
    else if (keep >= (64'd1 << 23)) r = {s, (ex == 0) ? 8'd1 : 8'(ex), keep[22:0]};
    else r = {s, 8'd0, keep[22:0]};
  endtask

  // Expectation shared with the compare process.
  int        cs = 0;
  int        lat = 0;
  bit [31:0] expR = 0;
  bit [31:0] heldR = 0;
  bit        inFlight = 0;

  always @(posedge clk) begin : compareProc
    bit rstAtEdge;
    bit expDone, expBusy;
    rstAtEdge = rst;
    #2;
    if (rstAtEdge) begin
      chk("reset done", 32'(done), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset R", R, 32'd0);
      heldR = 0;
      inFlight = 0;
    end else begin
      expDone = inFlight && (cyc == cs + lat);
      expBusy = inFlight && (cyc >= cs) && (cyc < cs + lat);
      chk("done timing", 32'(done), 32'(expDone));
      chk("busy", 32'(busy), 32'(expBusy));
      if (expDone) begin
        chk("result R", R, expR);
        heldR = expR;
      end else begin
        chk("held R", R, heldR);
      end
    end
  end

  task automatic launch(input vecT v);
    bit [31:0] mr;
    int ml;
    model(v.s, v.e, v.c, v.m, mr, ml);
    start = 1'b1; sign_in = v.s; exp_in = v.e; carry_in = v.c; mant_in = v.m;
    cs = cyc + 1;
    lat = ml;
    expR = mr;
    inFlight = 1;
  endtask

  // Called at a falling edge; returns at the falling edge of the done cycle
  // so the next call issues a back-to-back start.
  task automatic runOp(input vecT v);
    launch(v);
    @(negedge clk);
    start = 1'b0;
    while (cyc < cs + lat) begin
      if (v.glitch != 0 && cyc == cs + v.glitch) begin
        start = 1'b1; sign_in = 1'b1; exp_in = 8'h10; carry_in = 1'b1; mant_in = 27'h1234567;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic addVec(input bit s, input bit [7:0] e, input bit c, input bit [26:0] m,
                        input bit [31:0] rR, input int lR, input bit [31:0] rT, input int lT,
                        input int g);
    vecT v;
    v.s = s; v.e = e; v.c = c; v.m = m;
    v.rRound = rR; v.latRound = lR; v.rTrunc = rT; v.latTrunc = lT; v.glitch = g;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit [31:0] mr;
    int ml;
    rst = 1'b1; start = 1'b0; sign_in = 1'b0; exp_in = 8'd0; carry_in = 1'b0; mant_in = 27'd0;

    addVec(0, 8'd127, 0, 27'h4000000, 32'h3F800000, 3,  32'h3F800000, 2,  0); // 1.0
    addVec(0, 8'd127, 1, 27'h4000000, 32'h40400000, 3,  32'h40400000, 2,  0); // carry -> 3.0
    addVec(0, 8'd127, 0, 27'h0800000, 32'h3E000000, 6,  32'h3E000000, 5,  0); // k = 3
    addVec(0, 8'd127, 0, 27'h4000014, 32'h3F800002, 3,  32'h3F800002, 2,  0); // tie, even
    addVec(0, 8'd127, 0, 27'h4000004, 32'h3F800000, 3,  32'h3F800000, 2,  0); // tie, even
    addVec(0, 8'd127, 0, 27'h7FFFFFE, 32'h40000000, 3,  32'h3FFFFFFF, 2,  0); // round overflow
    addVec(0, 8'd254, 1, 27'h4000000, 32'h7F800000, 2,  32'h7F800000, 2,  0); // carry -> inf
    addVec(1, 8'd127, 0, 27'h0000000, 32'h80000000, 3,  32'h80000000, 2,  0); // -0
    addVec(0, 8'd1,   0, 27'h2000000, 32'h00400000, 3,  32'h00400000, 2,  0); // denormal
    addVec(0, 8'd255, 0, 27'h4000008, 32'h7F800001, 2,  32'h7F800001, 2,  0); // exp 255 pass
    addVec(0, 8'd254, 0, 27'h7FFFFFC, 32'h7F800000, 3,  32'h7F7FFFFF, 2,  0); // round -> inf
    addVec(0, 8'd127, 1, 27'h4000009, 32'h40400001, 3,  32'h40400000, 2,  0); // carry sticky
    addVec(0, 8'd1,   0, 27'h3FFFFFC, 32'h00800000, 3,  32'h007FFFFF, 2,  0); // denorm -> hidden
    addVec(0, 8'd127, 0, 27'h0000008, 32'h34000000, 26, 32'h34000000, 25, 8); // k = 23, start ignored
    addVec(0, 8'd127, 0, 27'h0000001, 32'h32800000, 29, 32'h32800000, 28, 0); // k = 26
    addVec(0, 8'd3,   0, 27'h0100000, 32'h00080000, 5,  32'h00080000, 4,  0); // exp floor stops NORM
    addVec(1, 8'd130, 0, 27'h1000000, 32'hC0000000, 5,  32'hC0000000, 4,  0); // negative, k = 2

    foreach (vecs[i]) begin
      model(vecs[i].s, vecs[i].e, vecs[i].c, vecs[i].m, mr, ml);
      chk($sformatf("model R vec%0d", i), mr, ROUND_EN ? vecs[i].rRound : vecs[i].rTrunc);
      chk($sformatf("model latency vec%0d", i), 32'(ml),
          32'(ROUND_EN ? vecs[i].latRound : vecs[i].latTrunc));
    end

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) runOp(vecs[i]);

    repeat (3) @(negedge clk);

    // Reset in the middle of NORM, together with a start that must be dropped.
    launch(vecs[13]);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; start = 1'b1; exp_in = 8'd127; mant_in = 27'h4000000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    runOp(vecs[0]);
    runOp(vecs[2]);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
